// File: rtl/song_reader.sv
// song_reader: steps through a per-song note table held in an external
// synchronous ROM and hands each {note, duration} pair to the note player.
// The table for song S lives at ROM words {S, 0 .. 2^ADDR_W-1}; a zero
// duration marks the end of the song, as does running off the last index.
//
// Handshake with the note player: new_note is a one-cycle strobe meaning
// "note/duration are valid now, start playing"; the player answers with a
// one-cycle note_done pulse when that note has finished. note_done is only
// consumed while waiting for it (WAIT_DONE) and is ignored at any other time.
module song_reader #(
  parameter int SONG_W = 2,
  parameter int ADDR_W = 5,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic                      reset_play,
  input  logic                      nextsong,
  input  logic                      note_done,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  output logic [SONG_W+ADDR_W-1:0]  rom_addr,
  output logic [NOTE_W-1:0]         note,
  output logic [DUR_W-1:0]          duration,
  output logic                      new_note,
  output logic                      song_done,
  output logic [SONG_W-1:0]         song,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_ROM  = 3'd2,
    S_NEW_NOTE  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_END       = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t              state_q;
  logic [SONG_W-1:0]   song_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NOTE_W-1:0]   note_q;
  logic [DUR_W-1:0]    duration_q;
  logic                new_note_q;
  logic                song_done_q;

  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;

  // Split the ROM word into its note and duration fields.
  always_comb begin
    rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
    rom_dur  = rom_data[DUR_W-1:0];
  end

  // Sequencer FSM. The strobes are registered one state early so that
  // new_note / song_done are high exactly while in the state that owns them:
  // the WAIT_ROM decision lands in NEW_NOTE, the last-index decision in END.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      song_q      <= '0;
      addr_q      <= '0;
      note_q      <= '0;
      duration_q  <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
      if (reset_play || nextsong) begin
        // Restart from note 0; note/duration keep their last values.
        addr_q  <= '0;
        state_q <= S_IDLE;
        if (nextsong) begin
          song_q <= song_q + 1'b1;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (play) begin
              state_q <= S_FETCH;
            end
          end
          S_FETCH: begin
            state_q <= S_WAIT_ROM;
          end
          S_WAIT_ROM: begin
            note_q     <= rom_note;
            duration_q <= rom_dur;
            if (rom_dur == '0) begin
              song_done_q <= 1'b1;
            end else begin
              new_note_q <= 1'b1;
            end
            state_q <= S_NEW_NOTE;
          end
          S_NEW_NOTE: begin
            state_q <= (duration_q == '0) ? S_END : S_WAIT_DONE;
          end
          S_WAIT_DONE: begin
            if (note_done) begin
              if (addr_q == ADDR_LAST) begin
                // Table exhausted: no wrap, finish the song.
                song_done_q <= 1'b1;
                state_q     <= S_END;
              end else begin
                addr_q  <= addr_q + 1'b1;
                state_q <= S_IDLE;
              end
            end
          end
          S_END: begin
            state_q <= S_END;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Outputs are straight from registers; the ROM address is their concatenation.
  always_comb begin
    rom_addr  = {song_q, addr_q};
    note      = note_q;
    duration  = duration_q;
    new_note  = new_note_q;
    song_done = song_done_q;
    song      = song_q;
    dbg_state = state_q;
  end

endmodule
